// File: rtl/t06_keypad_pkg.sv
// rtl/t06_keypad_pkg.sv - shared types and constants for the t06 keypad scanner
package t06_keypad_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2
  } scan_state_t;

  localparam int DEF_ROWS     = 4;
  localparam int DEF_COLS     = 4;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_DEBOUNCE = 3;

  // Width of an index into n items, never narrower than one bit.
  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t06_sync.sv
// rtl/t06_sync.sv - two-flop synchronizer for one asynchronous row line
module t06_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/t06_keypad_scan.sv
// rtl/t06_keypad_scan.sv - matrix keypad scanner with frame debounce and key event handshake
// Optional release events: define T06_KEYPAD_RELEASE_EN.
module t06_keypad_scan
  import t06_keypad_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [ROWS-1:0]                   row_in,
  output logic [COLS-1:0]                   col_drive,
  output logic                              key_valid,
  output logic [code_width(ROWS*COLS)-1:0]  key_code,
  input  logic                              key_ack,
  output logic                              key_down
`ifdef T06_KEYPAD_RELEASE_EN
  ,
  output logic                              key_release
`endif
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = code_width(NK);
  localparam int CIW = code_width(COLS);
  localparam int SW  = code_width(SETTLE);
  localparam int DW  = code_width(DEBOUNCE + 1);

  logic [ROWS-1:0] rows_sync;

  for (genvar r = 0; r < ROWS; r++) begin : g_sync
    t06_sync u_sync (
      .clk  (clk),
      .nrst (nrst),
      .d    (row_in[r]),
      .q    (rows_sync[r])
    );
  end

  scan_state_t    state, state_nx;
  logic [SW-1:0]  cnt, cnt_nx;
  logic [CIW-1:0] col, col_nx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_SETTLE;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    col_nx   = col;
    case (state)
      ST_SETTLE: begin
        if (cnt == SW'(SETTLE - 1)) state_nx = ST_SAMPLE;
        else                        cnt_nx   = cnt + 1'b1;
      end
      ST_SAMPLE: begin
        if (col == CIW'(COLS - 1)) begin
          state_nx = ST_EVAL;
        end else begin
          col_nx   = col + 1'b1;
          cnt_nx   = '0;
          state_nx = ST_SETTLE;
        end
      end
      ST_EVAL: begin
        col_nx   = '0;
        cnt_nx   = '0;
        state_nx = ST_SETTLE;
      end
      default: begin
        col_nx   = '0;
        cnt_nx   = '0;
        state_nx = ST_SETTLE;
      end
    endcase
  end

  assign col_drive = COLS'(1) << col;

  logic [NK-1:0] frame, frame_nx, prev_frame, deb, pend_press, press_clr;
  logic [DW-1:0] stable;
  logic          accept;

  // Drop the synced rows into the frame bits belonging to the driven column.
  always_comb begin
    frame_nx = frame;
    if (state == ST_SAMPLE) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (CIW'(c) == col) frame_nx[r*COLS + c] = rows_sync[r];
        end
      end
    end
  end

  assign accept = (state == ST_EVAL) && (frame == prev_frame) &&
                  (stable == DW'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame      <= '0;
      prev_frame <= '0;
      stable     <= '0;
      deb        <= '0;
    end else begin
      frame <= frame_nx;
      if (state == ST_EVAL) begin
        if (frame != prev_frame) begin
          prev_frame <= frame;
          stable     <= '0;
        end else if (stable != DW'(DEBOUNCE)) begin
          stable <= stable + 1'b1;
        end
        if (accept) deb <= frame;
      end
    end
  end

  logic [KW-1:0] arb_code;
  logic          arb_go;

`ifdef T06_KEYPAD_RELEASE_EN
  logic [NK-1:0] pend_rel, rel_clr;
  logic          arb_rel;

  // Presses always win; release indices are only chosen when no press is pending.
  always_comb begin
    arb_code = '0;
    arb_rel  = 1'b0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_rel[i]) begin
        arb_code = KW'(i);
        arb_rel  = 1'b1;
      end
    end
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_press[i]) begin
        arb_code = KW'(i);
        arb_rel  = 1'b0;
      end
    end
  end

  assign arb_go    = !key_valid && ((|pend_press) || (|pend_rel));
  assign press_clr = (arb_go && !arb_rel) ? (NK'(1) << arb_code) : '0;
  assign rel_clr   = (arb_go &&  arb_rel) ? (NK'(1) << arb_code) : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_rel    <= '0;
      key_release <= 1'b0;
    end else begin
      pend_rel <= (pend_rel & ~rel_clr) | (accept ? (deb & ~frame) : '0);
      if (!key_valid && arb_go) key_release <= arb_rel;
    end
  end
`else
  always_comb begin
    arb_code = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_press[i]) arb_code = KW'(i);
    end
  end

  assign arb_go    = !key_valid && (|pend_press);
  assign press_clr = arb_go ? (NK'(1) << arb_code) : '0;
`endif

  // Arbitration sees pend before this cycle's accept lands, so a fresh key waits one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_press <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
    end else begin
      pend_press <= (pend_press & ~press_clr) | (accept ? (frame & ~deb) : '0);
      if (key_valid) begin
        if (key_ack) key_valid <= 1'b0;
      end else if (arb_go) begin
        key_valid <= 1'b1;
        key_code  <= arb_code;
      end
    end
  end

  assign key_down = |deb;

endmodule

// File: tb/tb_t06_keypad_scan.sv
// tb/tb_t06_keypad_scan.sv - directed self-checking bench for t06_keypad_scan
module tb_t06_keypad_scan;

  localparam int FP = 21;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ack;
  logic       key_down;
`ifdef T06_KEYPAD_RELEASE_EN
  logic       key_release;
`endif

  logic [3:0] pr [4];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int row;
    int col;
    int code;
  } vec_t;

  vec_t vecs [5];

  t06_keypad_scan dut (
    .clk       (clk),
    .nrst      (nrst),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .key_down  (key_down)
`ifdef T06_KEYPAD_RELEASE_EN
    ,
    .key_release (key_release)
`endif
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a closed key shorts its column drive onto its row.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = |(pr[r] & col_drive);
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pr[r] = 4'b0000;
  endtask

  task automatic quiet(input string nm, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (key_valid) n++;
    end
    check(nm, n, 0);
  endtask

  task automatic wait_event(input string nm, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (key_valid) got = 1'b1;
    end
    check({nm, "_seen"}, int'(got), 1);
  endtask

  task automatic ack_event(input string nm);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check({nm, "_ack_clr"}, int'(key_valid), 0);
  endtask

  task automatic take_event(input string nm, input int code, input bit rel);
    bit got;
    string tag;
    tag = $sformatf("%s%s", nm, rel ? "_rel" : "_press");
    wait_event(tag, 6 * FP, got);
    if (got) begin
      check({tag, "_code"}, int'(key_code), code);
`ifdef T06_KEYPAD_RELEASE_EN
      check({tag, "_kind"}, int'(key_release), int'(rel));
`endif
      ack_event(tag);
    end
  endtask

  task automatic after_release(input string nm, input int c0, input int c1);
`ifdef T06_KEYPAD_RELEASE_EN
    take_event(nm, c0, 1'b1);
    if (c1 >= 0) take_event(nm, c1, 1'b1);
    quiet({nm, "_no_extra"}, FP);
`else
    quiet($sformatf("%s_silent_%0d_%0d", nm, c0, c1), 6 * FP);
`endif
    check({nm, "_key_down_off"}, int'(key_down), 0);
  endtask

  initial begin
    bit got;
    int n;
    int pos;
    int ecol;

    vecs[0] = '{row: 1, col: 2, code: 6};
    vecs[1] = '{row: 0, col: 0, code: 0};
    vecs[2] = '{row: 3, col: 3, code: 15};
    vecs[3] = '{row: 2, col: 1, code: 9};
    vecs[4] = '{row: 0, col: 3, code: 3};

    nrst    = 1'b0;
    key_ack = 1'b0;
    clear_keys();
    repeat (3) @(negedge clk);
    check("rst_col_drive", int'(col_drive), 1);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_down", int'(key_down), 0);
`ifdef T06_KEYPAD_RELEASE_EN
    check("rst_key_release", int'(key_release), 0);
`endif

    // Column walk: 5 cycles per column, the last column also covers the EVAL cycle.
    nrst = 1'b1;
    for (int t = 0; t < 2 * FP; t++) begin
      pos  = t % FP;
      ecol = (pos == FP - 1) ? 3 : pos / 5;
      check($sformatf("col_seq_t%0d", t), int'(col_drive), 1 << ecol);
      @(negedge clk);
    end
    quiet("idle_valid", 2 * FP);
    check("idle_key_down", int'(key_down), 0);

    foreach (vecs[i]) begin
      pr[vecs[i].row][vecs[i].col] = 1'b1;
      wait_event($sformatf("vec%0d", i), 5 * FP + 2, got);
      if (got) begin
        check($sformatf("vec%0d_code", i), int'(key_code), vecs[i].code);
`ifdef T06_KEYPAD_RELEASE_EN
        check($sformatf("vec%0d_kind", i), int'(key_release), 0);
`endif
        check($sformatf("vec%0d_key_down", i), int'(key_down), 1);
        ack_event($sformatf("vec%0d", i));
      end
      quiet($sformatf("vec%0d_held_once", i), 2 * FP);
      clear_keys();
      after_release($sformatf("vec%0d", i), vecs[i].code, -1);
    end

    pr[1][2] = 1'b1;
    repeat (2 * FP) @(negedge clk);
    clear_keys();
    quiet("bounce_no_event", 6 * FP);
    check("bounce_key_down", int'(key_down), 0);

    pr[0][1] = 1'b1;
    pr[3][2] = 1'b1;
    wait_event("pair", 6 * FP, got);
    if (got) begin
      check("pair_first_code", int'(key_code), 1);
      n = 0;
      repeat (30) begin
        @(negedge clk);
        if (!(key_valid && key_code == 4'd1)) n++;
      end
      check("pair_hold_stable", n, 0);
      ack_event("pair_first");
      @(negedge clk);
      check("pair_second_valid", int'(key_valid), 1);
      check("pair_second_code", int'(key_code), 14);
      ack_event("pair_second");
    end
    quiet("pair_no_third", FP);
    clear_keys();
    after_release("pair", 1, 14);

    pr[0][1] = 1'b1;
    pr[3][2] = 1'b1;
    wait_event("rst_pend", 6 * FP, got);
    n = 0;
    while (col_drive != 4'b0010 && n < 3 * FP) begin
      @(negedge clk);
      n++;
    end
    check("rst_find_settle", int'(col_drive), 2);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_col_drive", int'(col_drive), 1);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_key_code", int'(key_code), 0);
    check("midrst_key_down", int'(key_down), 0);
    clear_keys();
    @(negedge clk);
    nrst = 1'b1;
    quiet("midrst_no_stale", 6 * FP);
    check("midrst_key_down_after", int'(key_down), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
